// File: rtl/mem_access_unit.sv
// MEM-stage data-memory master: runs the data-RAM request/ready handshake for loads and stores,
// stalls the upstream pipeline while the bus is busy, and registers the WB bundle.
//
//   state  | meaning
//   IDLE   | pass ALU results straight to WB; a memory op stalls and launches the request
//   ACCESS | request held on the RAM port until ram_ready or wait-counter timeout
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] ex_result,
    input  logic        reg_write_en_in,
    input  logic [4:0]  reg_write_addr_in,
    input  logic [31:0] current_pc_addr_in,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ready,
    output logic        stall_request,
    output logic        bus_error,
    output logic [31:0] result,
    output logic        reg_write_en_out,
    output logic [4:0]  reg_write_addr_out,
    output logic [31:0] current_pc_addr_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [31:0]          result_q;
    logic                 reg_write_en_q;
    logic [4:0]           reg_write_addr_q;
    logic [31:0]          pc_q;
    logic                 bus_error_q;

    logic        mem_op;
    logic        cnt_at_last;
    logic [31:0] lane_mask;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign mem_op      = mem_read_flag | mem_write_flag;
    assign cnt_at_last = (cnt_q == CNT_LAST);
    assign lane_mask   = {{8{mem_sel[3]}}, {8{mem_sel[2]}}, {8{mem_sel[1]}}, {8{mem_sel[0]}}};

    always_comb begin
        load_data = ram_read_data & lane_mask;
        case (mem_sel)
            4'b0001: load_data = {{24{mem_sign_ext_flag & ram_read_data[7]}},  ram_read_data[7:0]};
            4'b0010: load_data = {{24{mem_sign_ext_flag & ram_read_data[15]}}, ram_read_data[15:8]};
            4'b0100: load_data = {{24{mem_sign_ext_flag & ram_read_data[23]}}, ram_read_data[23:16]};
            4'b1000: load_data = {{24{mem_sign_ext_flag & ram_read_data[31]}}, ram_read_data[31:24]};
            4'b0011: load_data = {{16{mem_sign_ext_flag & ram_read_data[15]}}, ram_read_data[15:0]};
            4'b1100: load_data = {{16{mem_sign_ext_flag & ram_read_data[31]}}, ram_read_data[31:16]};
            4'b1111: load_data = ram_read_data;
            default: load_data = ram_read_data & lane_mask;
        endcase
    end

    // Replicate narrow store data across the word so the strobes pick the right lane.
    always_comb begin
        store_data = mem_write_data;
        case (mem_sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: store_data = {4{mem_write_data[7:0]}};
            4'b0011, 4'b1100:                   store_data = {2{mem_write_data[15:0]}};
            default:                            store_data = mem_write_data;
        endcase
    end

    assign ram_en         = (state_q == ACCESS);
    assign ram_write_en   = (state_q == ACCESS && mem_write_flag) ? mem_sel : 4'b0000;
    assign ram_addr       = {ex_result[31:2], 2'b00};
    assign ram_write_data = store_data;
    assign stall_request  = (state_q == IDLE) ? mem_op : (!ram_ready && !cnt_at_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            result_q         <= 32'h0;
            reg_write_en_q   <= 1'b0;
            reg_write_addr_q <= 5'h0;
            pc_q             <= 32'h0;
            bus_error_q      <= 1'b0;
        end else begin
            bus_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        reg_write_en_q <= 1'b0;
                        cnt_q          <= '0;
                        state_q        <= ACCESS;
                    end else begin
                        result_q         <= ex_result;
                        reg_write_en_q   <= reg_write_en_in;
                        reg_write_addr_q <= reg_write_addr_in;
                        pc_q             <= current_pc_addr_in;
                    end
                end
                ACCESS: begin
                    if (ram_ready) begin
                        result_q         <= mem_write_flag ? ex_result : load_data;
                        reg_write_en_q   <= reg_write_en_in & ~mem_write_flag;
                        reg_write_addr_q <= reg_write_addr_in;
                        pc_q             <= current_pc_addr_in;
                        state_q          <= IDLE;
                    end else if (cnt_at_last) begin
                        bus_error_q    <= 1'b1;
                        result_q       <= 32'h0;
                        reg_write_en_q <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        reg_write_en_q <= 1'b0;
                        cnt_q          <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign result              = result_q;
    assign reg_write_en_out    = reg_write_en_q;
    assign reg_write_addr_out  = reg_write_addr_q;
    assign current_pc_addr_out = pc_q;
    assign bus_error           = bus_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes the expected WB bundle per op,
// a negedge monitor pops it on every retirement and checks bubbles in between.
module tb_mem_access_unit;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data, ex_result, current_pc_addr_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data, ram_read_data;
    logic        ram_ready;
    logic        stall_request, bus_error;
    logic [31:0] result, current_pc_addr_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;

    mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
        .mem_write_data(mem_write_data), .ex_result(ex_result),
        .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
        .current_pc_addr_in(current_pc_addr_in),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .ram_ready(ram_ready),
        .stall_request(stall_request), .bus_error(bus_error), .result(result),
        .reg_write_en_out(reg_write_en_out), .reg_write_addr_out(reg_write_addr_out),
        .current_pc_addr_out(current_pc_addr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] pc;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0, prev_ret = 0, prev_stall = 0;
    logic [3:0] sel_tab [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'h6};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [31:0] rdat, input logic [3:0] sel,
                                               input logic sx);
        int lane = 0;
        int width;
        logic [31:0] v, m;
        if (sel == 4'hF) return rdat;
        if ($countones(sel) == 1) begin
            for (int i = 0; i < 4; i++) if (sel[i]) lane = i;
            width = 8;
        end else if (sel == 4'h3 || sel == 4'hC) begin
            lane  = (sel == 4'h3) ? 0 : 2;
            width = 16;
        end else begin
            m = 32'h0;
            for (int i = 0; i < 4; i++) if (sel[i]) m = m | (32'hFF << (8 * i));
            return rdat & m;
        end
        m = (32'h1 << width) - 1;
        v = (rdat >> (8 * lane)) & m;
        if (sx && v[width-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] store_model(input logic [31:0] wd, input logic [3:0] sel);
        if ($countones(sel) == 1) return {4{wd[7:0]}};
        if (sel == 4'h3 || sel == 4'hC) return {2{wd[15:0]}};
        return wd;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_ret) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow actual=retire required=none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_result", result, mon_e.result);
                    chk("wb_we", reg_write_en_out, mon_e.we);
                    chk("wb_bus_error", bus_error, mon_e.berr);
                    if (!mon_e.berr) begin
                        chk("wb_waddr", reg_write_addr_out, mon_e.waddr);
                        chk("wb_pc", current_pc_addr_out, mon_e.pc);
                    end
                end
            end else if (prev_stall) begin
                chk("bubble_we", reg_write_en_out, 0);
                chk("bubble_bus_error", bus_error, 0);
            end
            prev_ret   = !stall_request;
            prev_stall = stall_request;
        end else begin
            prev_ret   = 0;
            prev_stall = 0;
        end
    end

    // d = ACCESS cycle index in which the RAM answers; d >= T means it never answers.
    task automatic do_op(input logic rd_f, input logic wr_f, input logic sx, input logic [3:0] sel,
                         input logic [31:0] wd, input logic [31:0] exr, input logic rwe,
                         input logic [4:0] rwa, input logic [31:0] pc, input logic [31:0] rdat,
                         input int d);
        exp_t e;
        bit   mop = rd_f | wr_f;
        bit   to  = mop && (d >= T);
        int   k = 0, ns = 0, exp_ns;
        bit   done = 0;
        @(posedge clk); #1;
        mem_read_flag = rd_f; mem_write_flag = wr_f; mem_sign_ext_flag = sx; mem_sel = sel;
        mem_write_data = wd; ex_result = exr; reg_write_en_in = rwe; reg_write_addr_in = rwa;
        current_pc_addr_in = pc; ram_read_data = rdat;
        e.berr   = to;
        e.result = to ? 32'h0 : ((mop && !wr_f) ? load_model(rdat, sel, sx) : exr);
        e.we     = !to && rwe && !wr_f;
        e.waddr  = rwa;
        e.pc     = pc;
        exp_q.push_back(e);
        mon_en = 1;
        // Stalled for the launching IDLE cycle plus every ACCESS cycle before the one that ends it.
        exp_ns = !mop ? 0 : (to ? T : 1 + d);
        while (!done) begin
            if (k > 0) begin @(posedge clk); #1; end
            ram_ready = (k == 0) ? 1'($urandom_range(0, 1)) : ((k - 1) == d);
            @(negedge clk);
            if (k == 0) chk("idle_ram_en", ram_en, 0);
            if (k == 1 && mop) begin
                chk("acc_ram_en", ram_en, 1);
                chk("acc_ram_addr", ram_addr, {exr[31:2], 2'b00});
                chk("acc_ram_we", ram_write_en, wr_f ? sel : 4'h0);
                if (wr_f) chk("acc_ram_wdata", ram_write_data, store_model(wd, sel));
            end
            if (stall_request) ns++;
            else done = 1;
            k++;
            if (!done && k > T + 4) begin
                checks++;
                errors++;
                $display("FAIL op_timeout actual=stalled_%0d required=%0d", ns, exp_ns);
                done = 1;
            end
        end
        chk("stall_cycles", ns, exp_ns);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ram_ready = 0; ram_read_data = 0;
        mem_read_flag = 0; mem_write_flag = 0; mem_sign_ext_flag = 0; mem_sel = 0;
        mem_write_data = 0; ex_result = 0; reg_write_en_in = 0; reg_write_addr_in = 0;
        current_pc_addr_in = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_write_en, 0);
        chk("rst_result", result, 0);
        chk("rst_we", reg_write_en_out, 0);
        chk("rst_waddr", reg_write_addr_out, 0);
        chk("rst_pc", current_pc_addr_out, 0);
        chk("rst_bus_error", bus_error, 0);
        chk("rst_stall", stall_request, 0);
        @(posedge clk); #1 rst = 0;

        do_op(0, 0, 0, 4'h0, 32'h0, 32'h1234, 1, 5'd5, 32'h1000, 32'h0, 0);
        do_op(1, 0, 1, 4'h8, 32'h0, 32'h103, 1, 5'd6, 32'h1004, 32'h80123456, 3);
        do_op(1, 0, 0, 4'hC, 32'h0, 32'h102, 1, 5'd7, 32'h1008, 32'h80015678, 1);
        do_op(0, 1, 0, 4'h4, 32'hAB, 32'h200, 1, 5'd8, 32'h100C, 32'h0, 0);
        do_op(1, 0, 1, 4'h3, 32'h0, 32'h300, 1, 5'd9, 32'h1010, 32'h0000F00D, T + 2);
        do_op(1, 0, 1, 4'h1, 32'h0, 32'h304, 1, 5'd10, 32'h1014, 32'h000000C3, T - 1);

        for (int n = 0; n < 150; n++) begin
            int kind = $urandom_range(0, 2);
            int r    = $urandom_range(0, 9);
            int d    = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? T - 1 : (r == 8) ? T : T + 3;
            logic [3:0] sel = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                          : sel_tab[$urandom_range(0, 8)];
            do_op(kind == 1, kind == 2, 1'($urandom_range(0, 1)), sel, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom, d);
        end

        @(posedge clk); #1;
        mem_read_flag = 0; mem_write_flag = 0; ex_result = 32'hDEAD0001; reg_write_en_in = 1;
        reg_write_addr_in = 5'd3; current_pc_addr_in = 32'h2000; ram_ready = 0;
        @(negedge clk); #1 mon_en = 0;
        chk("scoreboard_empty", exp_q.size(), 0);

        // Reset in the second ACCESS cycle must drop the op and clear everything.
        @(posedge clk); #1;
        mem_read_flag = 1; mem_sel = 4'hF; ex_result = 32'h300; reg_write_en_in = 1;
        reg_write_addr_in = 5'd7; current_pc_addr_in = 32'h40; ram_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("pre_rst_ram_en", ram_en, 1);
        chk("pre_rst_result", result, 32'hDEAD0001);
        @(posedge clk); #1;
        rst = 0; mem_read_flag = 0; ex_result = 0; reg_write_en_in = 0; reg_write_addr_in = 0;
        current_pc_addr_in = 0; ram_ready = 1;
        @(negedge clk);
        chk("mid_rst_ram_en", ram_en, 0);
        chk("mid_rst_ram_we", ram_write_en, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_we", reg_write_en_out, 0);
        chk("mid_rst_waddr", reg_write_addr_out, 0);
        chk("mid_rst_pc", current_pc_addr_out, 0);
        chk("mid_rst_bus_error", bus_error, 0);
        chk("mid_rst_stall", stall_request, 0);
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ram_en", ram_en, 0);
            chk("post_rst_bus_error", bus_error, 0);
            chk("post_rst_we", reg_write_en_out, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
